// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Keeps one request outstanding to a variable-latency memory, drops wrong-path responses and holds a skid word while ID stalls.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  jb_flag,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] skid_q, skid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  logic        redirect;
  logic [31:0] target_raw;
  logic [31:0] target;
  logic [31:0] pc_plus4;

  // jb_flag=11 shares the jump path; targets are always word aligned
  assign redirect   = (jb_flag != 2'b00);
  assign target_raw = (jb_flag == 2'b01) ? branch_target : jump_addr;
  assign target     = target_raw & 32'hFFFF_FFFC;
  assign pc_plus4   = pc_q + 32'd4;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    skid_d  = skid_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;

    // Redirect flushes, otherwise a non-stalled cycle bubbles unless a word loads below
    if (redirect || !stall) begin
      instr_d = '0;
      valid_d = 1'b0;
    end

    unique case (state_q)
      FETCH: begin
        addr_d = pc_q;
        if (redirect) begin
          pc_d    = target;
          state_d = DROP;
        end else begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (redirect) begin
          pc_d    = target;
          state_d = imem_rvalid ? FETCH : DROP;
        end else if (imem_rvalid && !stall) begin
          instr_d = imem_rdata;
          pc4_d   = pc_plus4;
          valid_d = 1'b1;
          pc_d    = pc_plus4;
          state_d = FETCH;
        end else if (imem_rvalid) begin
          skid_d  = imem_rdata;
          state_d = HOLD;
        end
      end

      HOLD: begin
        if (redirect) begin
          skid_d  = '0;
          pc_d    = target;
          state_d = FETCH;
        end else if (!stall) begin
          instr_d = skid_q;
          pc4_d   = pc_plus4;
          valid_d = 1'b1;
          pc_d    = pc_plus4;
          state_d = FETCH;
        end
      end

      DROP: begin
        // Latest redirect wins; leave only once the stale response has been absorbed
        if (redirect) begin
          pc_d = target;
        end
        if (imem_rvalid) begin
          state_d = FETCH;
        end
      end

      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC & 32'hFFFF_FFFC;
      addr_q  <= RESET_PC & 32'hFFFF_FFFC;
      skid_q  <= '0;
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      skid_q  <= skid_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  // Gated by reset so no request escapes while reset is held in FETCH
  assign imem_req       = (state_q == FETCH) && !reset;
  assign imem_addr      = (state_q == FETCH) ? pc_q : addr_q;
  assign if_id_instr    = instr_q;
  assign if_id_pc_plus4 = pc4_q;
  assign if_id_valid    = valid_q;

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage and IF/ID pipeline register. It produces the instruction word whose op and funct fields the ID-stage control unit decodes, and it consumes that stage's jump/branch redirect and stall indications.
- Owns the PC and issues single-outstanding requests to a variable-latency instruction memory.
- Discards wrong-path fetches on redirect and holds the fetched word while ID is stalled.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  ID-stage stall from the hazard logic; the same condition that forces the control unit to bubble.
- jb_flag  in  2  redirect code: 00 = none, 01 = taken branch, 10 = jump (J, JAL, JR).
- branch_target  in  32  branch target; used when jb_flag=01.
- jump_addr  in  32  jump target; used when jb_flag=10.
- imem_req  out  1  one-cycle fetch request pulse.
- imem_addr  out  32  fetch address; bits [1:0] always 0.
- imem_rvalid  in  1  one-cycle response strobe, arriving at least 1 cycle after imem_req.
- imem_rdata  in  32  instruction word; valid when imem_rvalid=1.
- if_id_instr  out  32  IF/ID instruction; op = [31:26], funct = [5:0].
- if_id_pc_plus4  out  32  PC+4 of if_id_instr.
- if_id_valid  out  1  1 = if_id_instr is a real instruction.

Behaviour:
- **Reset** (reset=1 at an edge):
  - pc=RESET_PC, state=FETCH, imem_req=0.
  - if_id_instr=32'h0, if_id_pc_plus4=0, if_id_valid=0, skid=0.
  - Reset overrides every other input.
  - The instruction memory shares the reset, so no response is pending after reset.
- **Target selection:** target = branch_target if jb_flag=01; jump_addr if jb_flag=10; jb_flag=11 is treated as 10. Target bits [1:0] are forced to 0.
- **Arithmetic:** pc+4 wraps modulo 2^32.
- **Outstanding requests:** at most one.
- **Request outputs:** imem_req=1 only in state FETCH, with imem_addr=pc. In all other states imem_addr holds the last issued address.
- **FSM states:** FETCH, WAIT, HOLD, DROP.
  - FETCH:
    - Issue the request and go to WAIT.
    - If jb_flag!=0 in the same cycle, the issued request is wrong-path: pc<=target, go to DROP.
  - WAIT, checked in priority order:
    - jb_flag!=0: pc<=target. If imem_rvalid=1 this cycle, discard the data and go to FETCH; otherwise go to DROP.
    - imem_rvalid=1 and stall=0: if_id_instr<=imem_rdata, if_id_pc_plus4<=pc+4, if_id_valid<=1, pc<=pc+4, go to FETCH.
    - imem_rvalid=1 and stall=1: skid<=imem_rdata, go to HOLD.
    - Otherwise stay in WAIT.
  - HOLD:
    - jb_flag!=0: discard skid, pc<=target, go to FETCH.
    - stall=0: IF/ID loads {skid, pc+4, valid=1}, pc<=pc+4, go to FETCH.
    - Otherwise stay in HOLD.
  - DROP:
    - jb_flag!=0: pc<=target (latest redirect wins); remain in DROP until the stale response arrives.
    - imem_rvalid=1: discard the data, go to FETCH.
- **IF/ID register rules, priority reset > redirect > stall > load:**
  - Redirect (jb_flag!=0, any state): IF/ID flushes to instr=32'h0 (a NOP, decoded as sll $0), valid=0, pc_plus4 unchanged.
  - If redirect and stall are asserted together, redirect wins and IF/ID is flushed.
  - stall=1 with no redirect: IF/ID holds its value.
  - No new word and no stall: IF/ID takes instr=32'h0, valid=0 (bubble).
  - IF/ID updates only on clock edges and is never combinational from imem_rdata.
- **Latency:** with a 1-cycle memory and no stalls, one instruction is delivered every 2 cycles. if_id_instr updates on the edge where imem_rvalid=1 is sampled.
- **No-redirect guarantee:** no imem_rvalid is ever lost or duplicated; every instruction reaches IF/ID exactly once and in order.

Test Plan:
- Straight line: RESET_PC=0, 1-cycle memory returning addr+32'h100, no stall/redirect.
  - Expect imem_addr 0,4,8,12 on successive FETCH cycles.
  - Expect if_id_instr 32'h100, 32'h104, ... with if_id_pc_plus4 4, 8, ... and valid=1.
- Stall capture: return the word 32'h2008_0005 with stall=1 held 3 cycles.
  - IF/ID holds its old value and no new imem_req is issued.
  - One edge after stall drops, IF/ID shows 32'h2008_0005 and pc advances by exactly 4.
- Jump in WAIT: 3-cycle memory, pulse jb_flag=10 with jump_addr=32'h0000_0040 one cycle after the request.
  - The stale response is dropped and IF/ID flushes to 0/valid=0.
  - The next imem_addr is 32'h40.
- Branch coincident with rvalid: jb_flag=01, branch_target=32'h0000_0200 in the same cycle as imem_rvalid.
  - The data is discarded and the next request goes to 32'h200 with no DROP wait.
- Redirect during HOLD plus double redirect in DROP:
  - Redirect in HOLD: skid is discarded.
  - Two jumps in DROP (32'h80, then 32'hC0): the fetch issues to 32'hC0.
- Reset mid-WAIT: assert reset while a request is pending.
  - Next cycle: outputs are zero, imem_req=0, valid=0.
  - First request after reset deasserts is at RESET_PC.
  - Wraparound: pc=32'hFFFF_FFFC delivers if_id_pc_plus4=0.
